// File: rtl/msk_and_hpc2_stream.sv
// rtl/msk_and_hpc2_stream.sv - W-bit-parallel d-share HPC2 masked AND, 2-stage valid/ready pipeline
// Stage 1 samples shares and randomness on accept; stage 2 holds the gadget products feeding the output XOR.
module msk_and_hpc2_stream #(
  parameter int d    = 2,
  parameter int W    = 1,
  parameter bit SWAP = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [d*W-1:0]                ina,
  input  logic [d*W-1:0]                inb,
  input  logic [W*(d*(d-1)/2)-1:0]      rnd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [d*W-1:0]                out
);

  localparam int RPB = d * (d - 1) / 2;

  typedef logic [d-1:0][W-1:0]         shr_t;
  typedef logic [d-1:0][d-1:0][W-1:0]  pair_t;

  // Row-major position of pair (i<j) inside one bit's randomness slice.
  function automatic int pair_idx(input int i, input int j);
    int base;
    base = 0;
    for (int m = 0; m < i; m++) base = base + (d - 1 - m);
    return base + (j - i - 1);
  endfunction

  shr_t  x_in, y_in;
  pair_t r_mat, u_d, v_d, s_d, t_d;
  shr_t  p_d, out_sh;

  pair_t u_r, v_r, s_r, t_r;
  shr_t  x1_r, p_r, q_r;
  logic  s1_valid, s2_valid;
  logic  s2_can_load, accept, advance;

  assign x_in = SWAP ? inb : ina;
  assign y_in = SWAP ? ina : inb;

  assign s2_can_load = !s2_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign accept      = in_valid && in_ready;
  assign advance     = s1_valid && s2_can_load;
  assign out_valid   = s2_valid;

  // Diagonal entries stay zero so they drop out of every later AND/XOR.
  always_comb begin
    r_mat = '0;
    u_d   = '0;
    v_d   = '0;
    p_d   = '0;
    for (int i = 0; i < d; i++) begin
      p_d[i] = x_in[i] & y_in[i];
      for (int j = 0; j < d; j++) begin
        if (i != j) begin
          for (int k = 0; k < W; k++) begin
            r_mat[i][j][k] = (i < j) ? rnd[k*RPB + pair_idx(i, j)]
                                     : rnd[k*RPB + pair_idx(j, i)];
          end
          u_d[i][j] = y_in[j] ^ r_mat[i][j];
          v_d[i][j] = r_mat[i][j];
        end
      end
    end
  end

  always_comb begin
    s_d = '0;
    t_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        s_d[i][j] = x1_r[i] & u_r[i][j];
        t_d[i][j] = ~x1_r[i] & v_r[i][j];
      end
    end
  end

  // Final share compression reads stage-2 registers only.
  always_comb begin
    out_sh = '0;
    for (int i = 0; i < d; i++) begin
      out_sh[i] = q_r[i];
      for (int j = 0; j < d; j++) begin
        out_sh[i] = out_sh[i] ^ s_r[i][j] ^ t_r[i][j];
      end
    end
  end

  assign out = out_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_r      <= '0;
      v_r      <= '0;
      x1_r     <= '0;
      p_r      <= '0;
      s_r      <= '0;
      t_r      <= '0;
      q_r      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        u_r  <= u_d;
        v_r  <= v_d;
        x1_r <= x_in;
        p_r  <= p_d;
      end
      if (advance) begin
        s_r <= s_d;
        t_r <= t_d;
        q_r <= p_r;
      end
      s1_valid <= accept || (s1_valid && !s2_can_load);
      if (s2_can_load) s2_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_stream.sv
// tb/tb_msk_and_hpc2_stream.sv - scoreboard bench for msk_and_hpc2_stream
// Main instance d=2,W=4; a SWAP=0/SWAP=1 pair at d=3 is run in lockstep.
module tb_msk_and_hpc2_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] ina = '0, inb = '0;
  logic [3:0] rnd = '0;
  logic       in_ready, out_valid;
  logic [7:0] out;

  logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic [11:0] ina3 = '0, inb3 = '0, rnd3 = '0;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [11:0] out_a, out_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int out_count = 0;
  logic mon_en = 1'b0;
  logic [7:0] sb[$];
  logic [3:0] q3[$];

  always #5 clk = ~clk;

  msk_and_hpc2_stream #(.d(2), .W(4), .SWAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out(out));

  msk_and_hpc2_stream #(.d(3), .W(4), .SWAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready_a),
    .ina(ina3), .inb(inb3), .rnd(rnd3),
    .out_valid(out_valid_a), .out_ready(out_ready3), .out(out_a));

  msk_and_hpc2_stream #(.d(3), .W(4), .SWAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready_b),
    .ina(ina3), .inb(inb3), .rnd(rnd3),
    .out_valid(out_valid_b), .out_ready(out_ready3), .out(out_b));

  // d=2 HPC2 output shares: out_i = x_i&y_i ^ x_i&y_j ^ r (x = ina).
  function automatic logic [7:0] model2(input logic [7:0] a, input logic [7:0] b, input logic [3:0] r);
    logic [3:0] x0, x1, y0, y1, o0, o1;
    x0 = a[3:0]; x1 = a[7:4]; y0 = b[3:0]; y1 = b[7:4];
    o0 = (x0 & y0) ^ (x0 & y1) ^ r;
    o1 = (x1 & y1) ^ (x1 & y0) ^ r;
    return {o1, o0};
  endfunction

  function automatic logic [3:0] unmask3(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        logic [7:0] e;
        total_cnt++;
        out_count++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_out: got %h, required no output", out);
        end else begin
          e = sb.pop_front();
          if (out !== e) $display("FAIL sb_out: got %h, required %h", out, e);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model2(ina, inb, rnd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 8'h00) $display("FAIL reset_out: got %h, required 00", out); else pass_cnt++;
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();
  endtask

  task automatic test_t1();
    out_ready = 1'b1;
    ina = 8'hA5; inb = 8'h03; rnd = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL t1_in_ready: got %b, required 1", in_ready); else pass_cnt++;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL t1_early_valid: got %b, required 0", out_valid); else pass_cnt++;
    cyc();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL t1_latency: got %b, required 1", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 8'h12) $display("FAIL t1_shares: got %h, required 12", out); else pass_cnt++;
    total_cnt++; if ((out[7:4] ^ out[3:0]) !== 4'h3) $display("FAIL t1_unmasked: got %h, required 3", out[7:4] ^ out[3:0]); else pass_cnt++;
    cyc();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL t1_single_beat: got %b, required 0", out_valid); else pass_cnt++;
    cyc();
  endtask

  task automatic test_stream();
    int start;
    start = out_count;
    out_ready = 1'b1;
    for (int n = 0; n < 64; n++) begin
      ina = 8'($urandom); inb = 8'($urandom); rnd = 4'($urandom); in_valid = 1'b1;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready: beat %0d got %b, required 1", n, in_ready); else pass_cnt++;
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    total_cnt++; if (out_count - start !== 64) $display("FAIL stream_count: got %0d, required 64", out_count - start); else pass_cnt++;
  endtask

  task automatic test_stall();
    int start;
    logic [7:0] held;
    logic [15:0] held_u, held_s;
    start = out_count;
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      ina = 8'($urandom); inb = 8'($urandom); rnd = 4'($urandom); in_valid = 1'b1;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_fill_ready: beat %0d got %b, required 1", n, in_ready); else pass_cnt++;
      cyc();
    end
    ina = 8'($urandom); inb = 8'($urandom); rnd = 4'($urandom);
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_full_ready: got %b, required 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid: got %b, required 1", out_valid); else pass_cnt++;
    held = out; held_u = dut0.u_r; held_s = dut0.s_r;
    for (int n = 0; n < 5; n++) begin
      cyc();
      ina = 8'($urandom); inb = 8'($urandom); rnd = 4'($urandom);
      @(negedge clk);
      total_cnt++; if (out !== held) $display("FAIL stall_out_hold: cycle %0d got %h, required %h", n, out, held); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %b, required 0", n, in_ready); else pass_cnt++;
      total_cnt++; if (dut0.u_r !== held_u || dut0.s_r !== held_s)
        $display("FAIL stall_regs_hold: cycle %0d got %h/%h, required %h/%h", n, dut0.u_r, dut0.s_r, held_u, held_s);
      else pass_cnt++;
    end
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    total_cnt++; if (out_count - start !== 2) $display("FAIL stall_drain_count: got %0d, required 2", out_count - start); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      ina = 8'($urandom); inb = 8'($urandom); rnd = 4'($urandom); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_pipe_full: got %b, required 1", out_valid); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b, required 0", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 8'h00) $display("FAIL rst_async_out: got %h, required 00", out); else pass_cnt++;
    sb.delete();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_stale_beat: cycle %0d got %b, required 0", n, out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: cycle %0d got %b, required 1", n, in_ready); else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_rnd_dependence();
    logic [7:0] o1, o2;
    out_ready = 1'b1;
    ina = 8'h3C; inb = 8'h96; rnd = 4'h0; in_valid = 1'b1;
    cyc();
    rnd = 4'hF;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rdep_valid1: got %b, required 1", out_valid); else pass_cnt++;
    o1 = out;
    cyc();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rdep_valid2: got %b, required 1", out_valid); else pass_cnt++;
    o2 = out;
    total_cnt++; if ((o1[7:4] ^ o1[3:0]) !== (o2[7:4] ^ o2[3:0]))
      $display("FAIL rdep_unmasked: got %h vs %h, required equal", o1[7:4] ^ o1[3:0], o2[7:4] ^ o2[3:0]);
    else pass_cnt++;
    total_cnt++; if (o1 === o2) $display("FAIL rdep_shares_differ: got %h and %h, required different", o1, o2); else pass_cnt++;
    cyc();
    repeat (2) cyc();
  endtask

  task automatic test_swap();
    logic [3:0] e;
    for (int n = 0; n < 80; n++) begin
      if (n < 70) begin
        in_valid3  = ($urandom_range(0, 3) != 0);
        out_ready3 = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
      end
      ina3 = 12'($urandom); inb3 = 12'($urandom); rnd3 = 12'($urandom);
      @(negedge clk);
      total_cnt++; if (out_valid_a !== out_valid_b || in_ready_a !== in_ready_b)
        $display("FAIL swap_handshake: got %b%b/%b%b, required equal", out_valid_a, in_ready_a, out_valid_b, in_ready_b);
      else pass_cnt++;
      if (out_valid_a && out_ready3) begin
        total_cnt++;
        if (q3.size() == 0) begin
          $display("FAIL swap_unexpected_out: got %h, required no output", out_a);
        end else begin
          e = q3.pop_front();
          if (unmask3(out_a) !== e || unmask3(out_b) !== e)
            $display("FAIL swap_result: got %h/%h, required %h", unmask3(out_a), unmask3(out_b), e);
          else pass_cnt++;
        end
      end
      if (in_valid3 && in_ready_a) q3.push_back(unmask3(ina3) & unmask3(inb3));
      cyc();
    end
    total_cnt++; if (q3.size() !== 0) $display("FAIL swap_drain: got %0d pending, required 0", q3.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_t1();
    test_stream();
    test_stall();
    test_reset_midop();
    test_rnd_dependence();
    test_swap();
    total_cnt++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
